led_pattern_seq: RTL and testbench

Sequencer for the LED value table: holds a 32-entry × 8-bit pattern table, reset-loaded with the Fibonacci values 0..233, and plays it onto the LED outputs at a programmable step rate in forward or bounce order. A host write port updates table entries while playback runs. Playback reads and host writes share the table under a fixed write-wins rule. The block sits between the CPU-side I/O registers and the board LED pins.

---
 rtl/led_pattern_seq_if.sv | 28 ++
 rtl/led_pattern_seq.sv | 154 +++++++++++++++
 tb/tb_led_pattern_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_seq_if.sv
// Host-side signal bundle for the LED pattern sequencer: playback control,
// table write port and display/status outputs.
interface led_pattern_seq_if #(
  parameter int DIV_W = 16
);
  logic             start;
  logic             stop;
  logic             bounce;
  logic [4:0]       len;
  logic [DIV_W-1:0] div;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [7:0]       wr_data;
  logic [7:0]       leds;
  logic             busy;
  logic             wrap;
  logic             wr_ack;

  modport master (
    output start, stop, bounce, len, div, wr_en, wr_addr, wr_data,
    input  leds, busy, wrap, wr_ack
  );

  modport slave (
    input  start, stop, bounce, len, div, wr_en, wr_addr, wr_data,
    output leds, busy, wrap, wr_ack
  );
endinterface

// File: rtl/led_pattern_seq.sv
// Plays a 32x8 pattern table onto the LEDs at a programmable dwell, forward or
// ping-pong; host writes land in the table every cycle and win over fetches.
//
// state | meaning
// IDLE  | leds hold last value, waiting for start without stop
// RUN   | counting dwell, stepping through table[0..len]
module led_pattern_seq #(
  parameter int DIV_W    = 16,
  parameter bit FIB_INIT = 1'b1
) (
  input logic              CLK,
  input logic              RST,
  led_pattern_seq_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [7:0]       pat_mem [32];
  logic [4:0]       idx, idx_next;
  logic             dir_down, dir_down_next;
  logic [DIV_W-1:0] cnt, cnt_next;
  logic [4:0]       len_q;
  logic [DIV_W-1:0] div_q;
  logic             bounce_q;
  logic [7:0]       leds_q, leds_next;
  logic             wrap_q, wrap_next;
  logic             ack_q;
  logic             latch;
  logic             fetch;
  logic [4:0]       fetch_idx;

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] a, b, t;
    a = 8'd0;
    b = 8'd1;
    for (int k = 0; k < 13; k++) begin
      if (k < i) begin
        t = a + b;
        a = b;
        b = t;
      end
    end
    if (!FIB_INIT || i > 13) return 8'd0;
    return a;
  endfunction

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    dir_down_next = dir_down;
    cnt_next      = cnt;
    wrap_next     = 1'b0;
    latch         = 1'b0;
    fetch         = 1'b0;
    fetch_idx     = idx;
    leds_next     = leds_q;

    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_next    = RUN;
          latch         = 1'b1;
          idx_next      = 5'd0;
          dir_down_next = 1'b0;
          cnt_next      = bus.div;
          fetch         = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else if (cnt != '0) begin
          cnt_next = cnt - DIV_W'(1);
        end else begin
          cnt_next = div_q;
          fetch    = 1'b1;
          if (!bounce_q || len_q == 5'd0) begin
            if (idx == len_q) begin
              idx_next  = 5'd0;
              wrap_next = 1'b1;
            end else begin
              idx_next = idx + 5'd1;
            end
          end else if (!dir_down) begin
            if (idx == len_q) begin
              idx_next      = len_q - 5'd1;
              dir_down_next = 1'b1;
            end else begin
              idx_next = idx + 5'd1;
            end
          end else begin
            idx_next = idx - 5'd1;
          end
          // Reaching index 0 in bounce mode always turns the direction back up.
          if (bounce_q && len_q != 5'd0 && idx_next == 5'd0) begin
            wrap_next     = 1'b1;
            dir_down_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    fetch_idx = idx_next;
    if (fetch) begin
      if (bus.wr_en && bus.wr_addr == fetch_idx) leds_next = bus.wr_data;
      else                                       leds_next = pat_mem[fetch_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= 5'd0;
      dir_down <= 1'b0;
      cnt      <= '0;
      len_q    <= 5'd0;
      div_q    <= '0;
      bounce_q <= 1'b0;
      leds_q   <= 8'd0;
      wrap_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      dir_down <= dir_down_next;
      cnt      <= cnt_next;
      leds_q   <= leds_next;
      wrap_q   <= wrap_next;
      ack_q    <= bus.wr_en;
      if (latch) begin
        len_q    <= bus.len;
        div_q    <= bus.div;
        bounce_q <= bus.bounce;
      end
    end
  end

  // Reset reload takes priority over a same-cycle host write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) pat_mem[i] <= init_val(i);
    end else if (bus.wr_en) begin
      pat_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.leds   = leds_q;
  assign bus.busy   = (state == RUN);
  assign bus.wrap   = wrap_q;
  assign bus.wr_ack = ack_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: forward, bounce, write bypass, stop and
// reset behaviour, each step checked against a hand-kept table model.
module tb_led_pattern_seq;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  led_pattern_seq_if #(.DIV_W(16)) bus ();

  led_pattern_seq #(.DIV_W(16), .FIB_INIT(1'b1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] fib [14];
  logic [7:0] tbl_m [32];
  int         pat6 [6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reload_model();
    for (int i = 0; i < 32; i++) tbl_m[i] = (i < 14) ? fib[i] : 8'd0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    fib[0] = 8'd0;
    fib[1] = 8'd1;
    for (int i = 2; i < 14; i++) fib[i] = fib[i-1] + fib[i-2];
    reload_model();
    pat6[0] = 0; pat6[1] = 1; pat6[2] = 2; pat6[3] = 3; pat6[4] = 2; pat6[5] = 1;

    bus.start = 0; bus.stop = 0; bus.bounce = 0; bus.len = 0; bus.div = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    tick(); tick();
    RST = 0;
    chk("rst_leds", bus.leds, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wrap", bus.wrap, 0);
    chk("rst_ack", bus.wr_ack, 0);

    // forward, div=0, len=13
    bus.start = 1; bus.len = 13; bus.div = 0; bus.bounce = 0;
    tick();
    bus.start = 0;
    chk("f13_entry_leds", bus.leds, tbl_m[0]);
    chk("f13_entry_busy", bus.busy, 1);
    chk("f13_entry_wrap", bus.wrap, 0);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("f13_leds", bus.leds, tbl_m[k % 14]);
      chk("f13_wrap", bus.wrap, (k == 14));
      chk("f13_busy", bus.busy, 1);
    end
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("f13_stop_busy", bus.busy, 0);
    chk("f13_stop_leds", bus.leds, tbl_m[0]);

    // forward, div=2, len=3; stop while index 3 is shown
    bus.start = 1; bus.len = 3; bus.div = 2;
    tick();
    bus.start = 0;
    bus.len = 9; bus.div = 0; bus.bounce = 1;
    chk("f3_entry_leds", bus.leds, tbl_m[0]);
    for (int k = 1; k <= 33; k++) begin
      tick();
      chk("f3_leds", bus.leds, tbl_m[(k / 3) % 4]);
      chk("f3_wrap", bus.wrap, (k % 12 == 0));
    end
    bus.stop = 1;
    tick();
    bus.stop = 0;
    for (int k = 0; k < 3; k++) begin
      chk("f3_stop_leds", bus.leds, tbl_m[3]);
      chk("f3_stop_busy", bus.busy, 0);
      tick();
    end

    // bounce, len=3, div=0
    bus.start = 1; bus.len = 3; bus.div = 0; bus.bounce = 1;
    tick();
    bus.start = 0;
    chk("b3_entry_leds", bus.leds, tbl_m[0]);
    chk("b3_entry_wrap", bus.wrap, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("b3_leds", bus.leds, tbl_m[pat6[k % 6]]);
      chk("b3_wrap", bus.wrap, (k % 6 == 0));
    end
    bus.stop = 1;
    tick();
    bus.stop = 0;

    // bounce, len=1
    bus.start = 1; bus.len = 1;
    tick();
    bus.start = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("b1_leds", bus.leds, tbl_m[k % 2]);
      chk("b1_wrap", bus.wrap, (k % 2 == 0));
    end
    bus.stop = 1;
    tick();
    bus.stop = 0;

    // bounce, len=0
    bus.start = 1; bus.len = 0;
    tick();
    bus.start = 0;
    chk("b0_entry_wrap", bus.wrap, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("b0_leds", bus.leds, tbl_m[0]);
      chk("b0_wrap", bus.wrap, 1);
    end
    bus.stop = 1;
    tick();
    bus.stop = 0;

    // write bypass on the fetch of index 1
    bus.start = 1; bus.len = 3; bus.div = 0; bus.bounce = 0;
    tick();
    bus.start = 0;
    chk("wb_entry_leds", bus.leds, tbl_m[0]);
    bus.wr_en = 1; bus.wr_addr = 1; bus.wr_data = 8'hAA;
    tick();
    bus.wr_en = 0;
    tbl_m[1] = 8'hAA;
    chk("wb_bypass_leds", bus.leds, 8'hAA);
    chk("wb_ack", bus.wr_ack, 1);
    tick();
    chk("wb_ack_clear", bus.wr_ack, 0);
    chk("wb_leds2", bus.leds, tbl_m[2]);
    tick();
    chk("wb_leds3", bus.leds, tbl_m[3]);
    tick();
    chk("wb_leds0", bus.leds, tbl_m[0]);
    chk("wb_wrap", bus.wrap, 1);
    tick();
    chk("wb_later_pass", bus.leds, 8'hAA);
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("wb_stop_leds", bus.leds, 8'hAA);
    chk("wb_stop_busy", bus.busy, 0);

    // write to the displayed index while idle: no fetch, leds unchanged
    bus.wr_en = 1; bus.wr_addr = 1; bus.wr_data = 8'h3C;
    tick();
    bus.wr_en = 0;
    tbl_m[1] = 8'h3C;
    chk("nf_leds", bus.leds, 8'hAA);
    chk("nf_ack", bus.wr_ack, 1);

    // start and stop together: stop wins
    bus.start = 1; bus.stop = 1;
    tick();
    chk("ss_busy", bus.busy, 0);
    chk("ss_leds", bus.leds, 8'hAA);
    tick();
    bus.start = 0; bus.stop = 0;
    chk("ss_busy2", bus.busy, 0);

    // write entry 5, run, then reset mid-run with a same-cycle write
    bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 8'h77;
    tick();
    bus.wr_en = 0;
    tbl_m[5] = 8'h77;
    chk("w5_ack", bus.wr_ack, 1);
    bus.start = 1; bus.len = 13; bus.div = 0;
    tick();
    bus.start = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("w5_leds", bus.leds, tbl_m[k]);
    end
    RST = 1;
    bus.wr_en = 1; bus.wr_addr = 6; bus.wr_data = 8'h55;
    tick();
    RST = 0;
    bus.wr_en = 0;
    reload_model();
    chk("mr_leds", bus.leds, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_wrap", bus.wrap, 0);
    chk("mr_ack", bus.wr_ack, 0);
    tick();
    chk("mr_ack2", bus.wr_ack, 0);
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("rr_entry_leds", bus.leds, tbl_m[0]);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("rr_leds", bus.leds, tbl_m[k]);
    end
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("rr_stop_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
